seq_int_divider: RTL and testbench

- Parametrised, multi-cycle integer divider: one quotient bit per clock (restoring algorithm).
- Signed or unsigned mode is selected per operation.
- Single-pulse start/done handshake.
- Serves as the shared division engine wherever a combinational "/" and "%" is too costly in area or timing; results match Verilog "/" and "%" semantics exactly.

---
 rtl/seq_div_pkg.sv | 22 ++
 rtl/seq_div_step.sv | 25 ++
 rtl/seq_int_divider.sv | 149 ++++++++++++++
 tb/tb_seq_int_divider.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared types and constants for the sequential integer divider
package seq_div_pkg;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 64;

    // Quotient pattern reported for a zero divisor (sliced to WIDTH by users)
    localparam logic [MAX_WIDTH-1:0] DBZ_QUOTIENT = {MAX_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } div_state_e;

    // Cycles from the accepting clock edge to the edge that raises done
    function automatic int div_latency(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// rtl/seq_div_step.sv - one combinational restoring-division iteration
module seq_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Shift in the next dividend bit and keep the difference when it does not go negative.
    // The partial remainder always stays below the divisor, so the shifted value fits in
    // WIDTH+1 bits; a set top bit of rem_i still forces a subtract for robustness.
    always_comb begin
        shifted = {rem_i[WIDTH-1:0], bit_i};
        diff    = shifted - {1'b0, divisor_i};
        qbit_o  = rem_i[WIDTH] | (shifted >= {1'b0, divisor_i});
        rem_o   = qbit_o ? diff : shifted;
    end

endmodule

// File: rtl/seq_int_divider.sv
// rtl/seq_int_divider.sv - multi-cycle signed/unsigned restoring integer divider
module seq_int_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit ZERO_FAST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state_q;
    logic [WIDTH-1:0] a_q;          // captured dividend (also the div-by-zero remainder)
    logic [WIDTH-1:0] b_q;          // captured divisor
    logic             sgn_q;        // captured is_signed
    logic [WIDTH-1:0] work_q;       // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] mag_b_q;
    logic [WIDTH:0]   rem_q;        // partial remainder, one extra bit for the carry
    logic [CW-1:0]    cnt_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] remo_q;
    logic             dbz_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a_d;
    logic [WIDTH-1:0] mag_b_d;
    logic             b_zero;
    logic [WIDTH-1:0] quot_d;
    logic [WIDTH-1:0] remo_d;
    logic [WIDTH:0]   step_rem;
    logic             step_qbit;

    // Operand magnitudes and final sign-corrected results
    always_comb begin
        a_neg   = sgn_q & a_q[WIDTH-1];
        b_neg   = sgn_q & b_q[WIDTH-1];
        mag_a_d = a_neg ? (~a_q + 1'b1) : a_q;
        mag_b_d = b_neg ? (~b_q + 1'b1) : b_q;
        b_zero  = (b_q == '0);
        if (b_zero) begin
            quot_d = DBZ_QUOTIENT[WIDTH-1:0];
            remo_d = a_q;
        end else begin
            quot_d = qneg_q ? (~work_q + 1'b1) : work_q;
            remo_d = rneg_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
        end
    end

    seq_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (work_q[WIDTH-1]),
        .divisor_i (mag_b_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    // Control FSM with registered datapath and outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            work_q  <= '0;
            mag_b_q <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q    <= dividend;
                        b_q    <= divisor;
                        sgn_q  <= is_signed;
                        busy_q <= 1'b1;
                        if (ZERO_FAST && (divisor == '0)) begin
                            state_q <= FIX;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    work_q  <= mag_a_d;
                    mag_b_q <= mag_b_d;
                    qneg_q  <= a_neg ^ b_neg;
                    rneg_q  <= a_neg;
                    rem_q   <= '0;
                    cnt_q   <= CW'(WIDTH - 1);
                    state_q <= CALC;
                end
                CALC: begin
                    rem_q  <= step_rem;
                    work_q <= {work_q[WIDTH-2:0], step_qbit};
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                FIX: begin
                    quot_q  <= quot_d;
                    remo_q  <= remo_d;
                    dbz_q   <= b_zero;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_int_divider.sv
// tb/tb_seq_int_divider.sv - self-checking bench for seq_int_divider (fast and slow zero paths)
module tb_seq_int_divider;
    import seq_div_pkg::*;

    localparam int W   = 8;
    localparam int LAT = div_latency(W);

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;

    logic         busy_f, done_f, dbz_f;
    logic [W-1:0] q_f, r_f;
    logic         busy_s, done_s, dbz_s;
    logic [W-1:0] q_s, r_s;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    always #5 clk = ~clk;

    seq_int_divider #(.WIDTH(W), .ZERO_FAST(1'b1)) dut_f (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy_f), .done(done_f),
        .quotient(q_f), .remainder(r_f), .div_by_zero(dbz_f)
    );

    seq_int_divider #(.WIDTH(W), .ZERO_FAST(1'b0)) dut_s (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy_s), .done(done_s),
        .quotient(q_s), .remainder(r_s), .div_by_zero(dbz_s)
    );

    // Reference: Verilog "/" and "%" on wide integers, plus the zero-divisor rule
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa, sb, qq, rr;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
            return;
        end
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        qq = sa / sb;
        rr = sa % sb;
        q  = qq[W-1:0];
        r  = rr[W-1:0];
        z  = 1'b0;
    endfunction

    // Issue one operation from a negedge, scramble inputs after acceptance, collect both results
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output int lat_f, output int lat_s,
                          output logic [2*W:0] res_f, output logic [2*W:0] res_s,
                          output logic busy_ok);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        lat_f     = -1;
        lat_s     = -1;
        res_f     = '0;
        res_s     = '0;
        busy_ok   = 1'b1;
        for (int i = 0; i < 4 * LAT; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 0) begin
                start     = 1'b0;
                dividend  = W'($urandom);
                divisor   = W'($urandom);
                is_signed = 1'($urandom);
            end
            if (lat_f < 0) begin
                if (done_f) begin
                    lat_f = i;
                    res_f = {q_f, r_f, dbz_f};
                    if (busy_f) busy_ok = 1'b0;
                end else if (!busy_f) begin
                    busy_ok = 1'b0;
                end
            end
            if (lat_s < 0) begin
                if (done_s) begin
                    lat_s = i;
                    res_s = {q_s, r_s, dbz_s};
                    if (busy_s) busy_ok = 1'b0;
                end else if (!busy_s) begin
                    busy_ok = 1'b0;
                end
            end
            if (lat_f >= 0 && lat_s >= 0) break;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy_f, done_f, q_f, r_f, dbz_f} !== '0) begin
            n_fail++;
            $display("FAIL reset_fast: got %h expected 0", {busy_f, done_f, q_f, r_f, dbz_f});
        end
        n_checks++;
        if ({busy_s, done_s, q_s, r_s, dbz_s} !== '0) begin
            n_fail++;
            $display("FAIL reset_slow: got %h expected 0", {busy_s, done_s, q_s, r_s, dbz_s});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        vec_t         vecs [0:6];
        int           lf, ls;
        logic [2*W:0] rf, rs, exp;
        logic         bok;
        vecs = '{
            '{8'h24, 8'h04, 1'b0, 8'h09, 8'h00, 1'b0},
            '{8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0},
            '{8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0},
            '{8'h5A, 8'h00, 1'b0, 8'hFF, 8'h5A, 1'b1},
            '{8'h5A, 8'h00, 1'b1, 8'hFF, 8'h5A, 1'b1},
            '{8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0},
            '{8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0}
        };
        for (int k = 0; k < 7; k++) begin
            run_op(vecs[k].a, vecs[k].b, vecs[k].s, lf, ls, rf, rs, bok);
            exp = {vecs[k].q, vecs[k].r, vecs[k].z};
            n_checks++;
            if (rf !== exp) begin
                n_fail++;
                $display("FAIL directed_fast[%0d]: got %h expected %h", k, rf, exp);
            end
            n_checks++;
            if (rs !== exp) begin
                n_fail++;
                $display("FAIL directed_slow[%0d]: got %h expected %h", k, rs, exp);
            end
            n_checks++;
            if (lf != ((vecs[k].b == '0) ? 1 : LAT)) begin
                n_fail++;
                $display("FAIL directed_lat_fast[%0d]: got %0d", k, lf);
            end
            n_checks++;
            if (ls != LAT) begin
                n_fail++;
                $display("FAIL directed_lat_slow[%0d]: got %0d expected %0d", k, ls, LAT);
            end
            n_checks++;
            if (bok !== 1'b1) begin
                n_fail++;
                $display("FAIL directed_busy[%0d]: got %b expected 1", k, bok);
            end
        end
    endtask

    task automatic test_random();
        int           lf, ls;
        logic [2*W:0] rf, rs;
        logic [W-1:0] a, b, eq, er;
        logic         s, ez, bok;
        for (int k = 0; k < 40; k++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 3) == 0) b = W'($urandom_range(1, 3)) ^ {W{b[W-1]}};
            s = 1'($urandom);
            model(a, b, s, eq, er, ez);
            run_op(a, b, s, lf, ls, rf, rs, bok);
            n_checks++;
            if (rf !== {eq, er, ez} || rs !== {eq, er, ez}) begin
                n_fail++;
                $display("FAIL random[%0d] %h/%h s=%b: got %h,%h expected %h",
                         k, a, b, s, rf, rs, {eq, er, ez});
            end
            n_checks++;
            if (lf != ((b == '0) ? 1 : LAT) || ls != LAT || !bok) begin
                n_fail++;
                $display("FAIL random_timing[%0d]: got lat %0d/%0d busy_ok %b", k, lf, ls, bok);
            end
        end
    endtask

    task automatic test_back_to_back();
        int found;
        dividend  = 8'h64;
        divisor   = 8'h07;
        is_signed = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        dividend  = 8'h11;
        divisor   = 8'h03;
        is_signed = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3 * LAT && !done_f; k++) @(negedge clk);
        n_checks++;
        if ({done_f, done_s, q_f, r_f, q_s, r_s} !== {1'b1, 1'b1, 8'h0E, 8'h02, 8'h0E, 8'h02}) begin
            n_fail++;
            $display("FAIL ignore_start: got %h expected %h", {done_f, done_s, q_f, r_f, q_s, r_s},
                     {1'b1, 1'b1, 8'h0E, 8'h02, 8'h0E, 8'h02});
        end
        dividend  = 8'hC8;
        divisor   = 8'h0D;
        is_signed = 1'b0;
        start     = 1'b1;
        found     = -1;
        for (int i = 0; i < 3 * LAT; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
                n_checks++;
                if ({done_f, done_s, busy_f, busy_s} !== 4'b0011) begin
                    n_fail++;
                    $display("FAIL b2b_accept: got %b expected 0011", {done_f, done_s, busy_f, busy_s});
                end
            end
            if (done_f) begin
                found = i;
                break;
            end
        end
        n_checks++;
        if (found != LAT) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d expected %0d", found, LAT);
        end
        n_checks++;
        if ({q_f, r_f, q_s, r_s, done_s} !== {8'h0F, 8'h05, 8'h0F, 8'h05, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_result: got %h expected %h", {q_f, r_f, q_s, r_s, done_s},
                     {8'h0F, 8'h05, 8'h0F, 8'h05, 1'b1});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int           lf, ls, seen;
        logic [2*W:0] rf, rs;
        logic         bok;
        dividend  = 8'hF0;
        divisor   = 8'h03;
        is_signed = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy_f, done_f, q_f, r_f, dbz_f, busy_s, done_s, q_s, r_s, dbz_s} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h expected 0",
                     {busy_f, done_f, q_f, r_f, dbz_f, busy_s, done_s, q_s, r_s, dbz_s});
        end
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        for (int k = 0; k < 2 * LAT; k++) begin
            @(negedge clk);
            if (done_f || done_s || busy_f || busy_s) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d active cycles expected 0", seen);
        end
        run_op(8'hF0, 8'h03, 1'b0, lf, ls, rf, rs, bok);
        n_checks++;
        if (rf !== {8'h50, 8'h00, 1'b0} || rs !== {8'h50, 8'h00, 1'b0} || lf != LAT || !bok) begin
            n_fail++;
            $display("FAIL reset_recover: got %h,%h lat %0d expected %h lat %0d",
                     rf, rs, lf, {8'h50, 8'h00, 1'b0}, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
